rf_writeback: RTL
=================

// Module: rf_writeback
// PURPOSE
//  Write-side controller for the 8-bit register file: the single producer of its write port (wen/addr/data).
//  Merges single-cycle ALU results with in-order data-memory load returns and queues load destinations.
//  Keeps a per-register pending-load scoreboard so decode can stall reads of registers still awaiting a load.
//  Sits between execute/memory stages and the register file.
// PARAMETERS
//  RAW        4  register address width (2**RAW registers)
//  DW         8  data width
//  LDQ_DEPTH  4  max outstanding loads (power of 2, >=2)
// PORTS
//  clk            in   1          clock; all state updates on posedge
//  reset          in   1          synchronous, active-high
//  alu_valid_i    in   1          ALU result offered
//  alu_rd_i       in   RAW        ALU destination register
//  alu_data_i     in   DW         ALU result
//  alu_ready_o    out  1          ALU result accepted this cycle (comb.)
//  ld_valid_i     in   1          load issued to memory; dest must be queued
//  ld_rd_i        in   RAW        load destination register
//  ld_ready_o     out  1          load queue not full (comb.)
//  mem_rvalid_i   in   1          memory returns oldest outstanding load data (cannot stall)
//  mem_rdata_i    in   DW         returned load data
//  rf_wen_o       out  1          register-file write enable (registered)
//  rf_waddr_o     out  RAW        register-file write address (registered)
//  rf_wdata_o     out  DW         register-file write data (registered)
//  busy_o         out  2**RAW     bit r = 1 while register r has a load pending (incl. the commit cycle)
//  err_o          out  1          sticky: mem_rvalid_i seen with empty load queue
// BEHAVIOUR
//  Reset: queue empty, all pending counters 0; rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0.
//    Reset wins over every other input in the same cycle, including mid-flight loads.
//  Latency: an accepted result appears on rf_* exactly 1 cycle later, for one cycle. No internal result buffering.
//  Arbitration per cycle:
//    - mem_rvalid_i with queue non-empty: pop head rd; next rf_* = {1, head_rd, mem_rdata_i}. Memory has absolute priority.
//    - Otherwise alu_valid_i && alu_ready_o: next rf_* = {1, alu_rd_i, alu_data_i}.
//    - Otherwise next rf_wen_o=0; rf_waddr_o/rf_wdata_o hold their previous values.
//  alu_ready_o = !(mem_rvalid_i && !q_empty) && !busy[alu_rd_i]
//    - The second term is the WAW guard: an ALU result never overtakes an older load to the same register.
//  Load queue: FIFO of RAW-bit destinations.
//    - ld_ready_o = !q_full || (mem_rvalid_i && !q_empty), i.e. a push is allowed on a full queue when a pop happens in the same cycle.
//    - Push on ld_valid_i && ld_ready_o.
//    - Pointers wrap modulo LDQ_DEPTH; count width is $clog2(LDQ_DEPTH+1).
//  Scoreboard: per-register counter, width $clog2(LDQ_DEPTH+1).
//    - +1 on push to r; -1 when a pop of r commits.
//    - Push and pop to the same r in the same cycle: counter unchanged.
//    - busy_o[r] = (cnt[r] != 0); registered and updated with the queue.
//  Empty-queue return: mem_rvalid_i while q_empty (no same-cycle push counts) sets err_o.
//    - Data dropped, rf_wen_o=0 next cycle; err_o clears only on reset.
//  ld_valid_i while !ld_ready_o: ignored (no push); upstream must hold and retry.
//  Register 0 is not special; writes to r0 commit like any other.
// STRUCTURE
//  Package wb_pkg: RAW, DW, LDQ_DEPTH defaults; typedef logic [RAW-1:0] reg_addr_t; typedef logic [DW-1:0] word_t;
//    localparam CNT_W = $clog2(LDQ_DEPTH+1).
//  Sub-module wb_ldq: synchronous FIFO (push/pop/full/empty/head), same clk/reset; scoreboard and arbitration stay in rf_writeback.
// TESTING
//  1 Reset -> rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, err_o=0, ld_ready_o=1.
//  2 ALU alone: alu_valid_i=1, rd=3, data=8'h5A -> alu_ready_o=1; next cycle rf_wen_o=1, rf_waddr_o=3, rf_wdata_o=8'h5A; cycle after, rf_wen_o=0.
//  3 Load rd=5, then mem_rvalid_i with data=8'hC3 in the same cycle as ALU rd=2 data=8'h11
//      -> busy_o[5]=1 until commit; ALU stalled (alu_ready_o=0) that cycle; next cycle writes 5<-C3; ALU writes 2<-11 the cycle after.
//  4 WAW: load rd=7 pending, ALU rd=7 data=8'h01 offered -> alu_ready_o=0 until the load commits, then ALU accepted; final r7 = 8'h01.
//  5 Full: issue 4 loads (rd=1,1,2,3) -> ld_ready_o=0, cnt[1]=2.
//      5th ld_valid_i together with mem_rvalid_i -> push accepted, queue stays full; busy_o[1] clears only after the second r1 return.
//  6 mem_rvalid_i with empty queue -> err_o=1 sticky, no write.
//      Then reset asserted with 2 loads outstanding -> queue empty, busy_o=0, err_o=0 the next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared sizes and types for the register-file write-back controller.
package wb_pkg;

  localparam int unsigned RAW       = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned LDQ_DEPTH = 4;
  localparam int unsigned NREG      = 2 ** RAW;
  localparam int unsigned CNT_W     = $clog2(LDQ_DEPTH + 1);

  typedef logic [RAW-1:0] reg_addr_t;
  typedef logic [DW-1:0]  word_t;

endpackage

// File: rtl/wb_ldq.sv
// In-order queue of outstanding load destinations; a push on a full queue is legal
// when a pop happens in the same cycle.
module wb_ldq #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (push_i && !pop_i) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Sole driver of the register-file write port: merges ALU results with in-order load
// returns and tracks per-register pending loads for decode stalls.
module rf_writeback
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid_i,
  input  reg_addr_t       alu_rd_i,
  input  word_t           alu_data_i,
  output logic            alu_ready_o,
  input  logic            ld_valid_i,
  input  reg_addr_t       ld_rd_i,
  output logic            ld_ready_o,
  input  logic            mem_rvalid_i,
  input  word_t           mem_rdata_i,
  output logic            rf_wen_o,
  output reg_addr_t       rf_waddr_o,
  output word_t           rf_wdata_o,
  output logic [NREG-1:0] busy_o,
  output logic            err_o
);

  logic      q_full, q_empty, pop, push;
  reg_addr_t q_head;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic      rf_wen_q, rf_wen_d;
  reg_addr_t rf_waddr_q, rf_waddr_d;
  word_t     rf_wdata_q, rf_wdata_d;
  logic      err_q, err_d;

  assign pop         = mem_rvalid_i && !q_empty;
  assign alu_ready_o = !pop && !busy_o[alu_rd_i];
  assign ld_ready_o  = !q_full || pop;
  assign push        = ld_valid_i && ld_ready_o;

  wb_ldq #(
    .Depth (LDQ_DEPTH),
    .Width (RAW)
  ) u_ldq (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (ld_rd_i),
    .pop_i   (pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc      = push && (ld_rd_i == reg_addr_t'(r));
      dec      = pop && (q_head == reg_addr_t'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      busy_o[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = q_head;
      rf_wdata_d = mem_rdata_i;
    end else if (alu_valid_i && alu_ready_o) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = alu_rd_i;
      rf_wdata_d = alu_data_i;
    end
    // A return with nothing outstanding is a protocol error; its data is dropped.
    err_d = err_q || (mem_rvalid_i && q_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign rf_wen_o   = rf_wen_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign err_o      = err_q;

endmodule
